// File: rtl/load_down_counter_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
// The prescaler default only matters when LOAD_DOWN_COUNTER_PRESCALE_EN is defined.
package load_down_counter_pkg;

    localparam int DEFAULT_W        = 18;
    localparam int DEFAULT_PRESCALE = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/load_down_counter_tick_prescaler.sv
// Divides enabled cycles by PRESCALE: tick is high on the enabled cycle that wraps the count.
// Only instantiated when LOAD_DOWN_COUNTER_PRESCALE_EN is defined.
module tick_prescaler
    import load_down_counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/load_down_counter.sv
// Loadable down-counter/timer with terminal-count strobe and optional auto-reload.
// Define LOAD_DOWN_COUNTER_PRESCALE_EN to decrement only every PRESCALE enabled cycles.
//
// state | meaning
// IDLE  | waiting for a load; load_ready=1
// RUN   | counting down; busy=1, loads ignored
module load_down_counter
    import load_down_counter_pkg::*;
#(
    parameter int W = DEFAULT_W
`ifdef LOAD_DOWN_COUNTER_PRESCALE_EN
    , parameter int PRESCALE = DEFAULT_PRESCALE
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_value,
    input  logic         reload,
    input  logic         stop,
    output logic [W-1:0] cntr,
    output logic         tc,
    output logic         busy
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [W-1:0]   cntr_q, cntr_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           tc_q, tc_d;
    logic           step;

`ifdef LOAD_DOWN_COUNTER_PRESCALE_EN
    logic pre_en, pre_clr;

    // Held clear outside RUN so every load starts a full prescale period.
    assign pre_en  = (state_q == RUN) && en && !stop;
    assign pre_clr = (state_q != RUN) || stop || (step && (cntr_q <= ONE));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (step)
    );
`else
    assign step = en;
`endif

    always_comb begin
        state_d  = state_q;
        cntr_d   = cntr_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    cntr_d   = load_value;
                    reload_d = load_value;
                    if (load_value != '0) begin
                        state_d = RUN;
                    end else begin
                        tc_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (step) begin
                    if (cntr_q > ONE) begin
                        cntr_d = cntr_q - ONE;
                    end else begin
                        tc_d = 1'b1;
                        if (reload) begin
                            cntr_d = reload_q;
                        end else begin
                            cntr_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cntr_q   <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cntr_q   <= cntr_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign cntr       = cntr_q;
    assign tc         = tc_q;
    assign busy       = (state_q == RUN);
    assign load_ready = (state_q == IDLE);

endmodule
